// File: rtl/decoder_scan_sequencer.sv
// rtl/decoder_scan_sequencer.sv - select/enable sequencer feeding a 4-to-16 decoder stage
// Optional one-clock anti-ghosting blank between indices when SCAN_BLANK_EN is defined.
module decoder_scan_sequencer #(
    parameter int DWELL_CYCLES = 4,
    parameter int LAST_INDEX   = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic       cont,
    output logic [3:0] sel,
    output logic       sel_en,
    output logic       busy,
    output logic       done,
    output logic       wrap_tick
);
    localparam logic [7:0] DWELL_LAST = 8'(DWELL_CYCLES - 1);
    localparam logic [3:0] SEL_LAST   = 4'(LAST_INDEX);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1
`ifdef SCAN_BLANK_EN
        , BLANK = 2'd2
`endif
    } state_t;

    state_t     state;
    logic [7:0] dwell;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            sel       <= 4'd0;
            sel_en    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            wrap_tick <= 1'b0;
            dwell     <= 8'd0;
        end else begin
            done      <= 1'b0;
            wrap_tick <= 1'b0;
            case (state)
                IDLE: begin
                    sel    <= 4'd0;
                    sel_en <= 1'b0;
                    busy   <= 1'b0;
                    dwell  <= 8'd0;
                    if (start && !stop) begin
                        state  <= ACTIVE;
                        sel_en <= 1'b1;
                        busy   <= 1'b1;
                    end
                end
                ACTIVE: begin
                    // stop outranks any dwell expiry landing in the same cycle
                    if (stop) begin
                        state  <= IDLE;
                        sel    <= 4'd0;
                        sel_en <= 1'b0;
                        busy   <= 1'b0;
                        dwell  <= 8'd0;
                    end else if (dwell == DWELL_LAST) begin
                        dwell <= 8'd0;
                        if (sel != SEL_LAST || cont) begin
                            sel       <= (sel == SEL_LAST) ? 4'd0 : sel + 4'd1;
                            wrap_tick <= (sel == SEL_LAST);
`ifdef SCAN_BLANK_EN
                            state  <= BLANK;
                            sel_en <= 1'b0;
`endif
                        end else begin
                            state  <= IDLE;
                            sel    <= 4'd0;
                            sel_en <= 1'b0;
                            busy   <= 1'b0;
                            done   <= 1'b1;
                        end
                    end else begin
                        dwell <= dwell + 8'd1;
                    end
                end
`ifdef SCAN_BLANK_EN
                BLANK: begin
                    // sel already points at the next index; only the enable is held off
                    if (stop) begin
                        state  <= IDLE;
                        sel    <= 4'd0;
                        sel_en <= 1'b0;
                        busy   <= 1'b0;
                    end else begin
                        state  <= ACTIVE;
                        sel_en <= 1'b1;
                    end
                    dwell <= 8'd0;
                end
`endif
                default: begin
                    state  <= IDLE;
                    sel    <= 4'd0;
                    sel_en <= 1'b0;
                    busy   <= 1'b0;
                    dwell  <= 8'd0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_decoder_scan_sequencer.sv
// tb/tb_decoder_scan_sequencer.sv - self-checking bench for decoder_scan_sequencer (SCAN_BLANK_EN aware)
module tb_decoder_scan_sequencer;
    localparam int NI = 6;
`ifdef SCAN_BLANK_EN
    localparam int BL = 1;
    localparam int WRAP_P = 16;
    localparam int DONE_AT = 32;
    localparam int WRAPS10 = 5;
`else
    localparam int BL = 0;
    localparam int WRAP_P = 12;
    localparam int DONE_AT = 17;
    localparam int WRAPS10 = 10;
`endif
    localparam int DWA [NI] = '{2, 3, 4, 1, 1, 2};
    localparam int LIA [NI] = '{15, 3, 15, 15, 0, 2};

    logic clk = 1'b0;
    logic rst;
    logic st [NI];
    logic sp [NI];
    logic ct [NI];
    logic [3:0] sel_o [NI];
    logic en_o [NI];
    logic busy_o [NI];
    logic done_o [NI];
    logic wrap_o [NI];

    always #5 clk = ~clk;

    decoder_scan_sequencer #(.DWELL_CYCLES(2), .LAST_INDEX(15)) u0 (.clk(clk), .rst(rst), .start(st[0]), .stop(sp[0]), .cont(ct[0]),
        .sel(sel_o[0]), .sel_en(en_o[0]), .busy(busy_o[0]), .done(done_o[0]), .wrap_tick(wrap_o[0]));
    decoder_scan_sequencer #(.DWELL_CYCLES(3), .LAST_INDEX(3)) u1 (.clk(clk), .rst(rst), .start(st[1]), .stop(sp[1]), .cont(ct[1]),
        .sel(sel_o[1]), .sel_en(en_o[1]), .busy(busy_o[1]), .done(done_o[1]), .wrap_tick(wrap_o[1]));
    decoder_scan_sequencer #(.DWELL_CYCLES(4), .LAST_INDEX(15)) u2 (.clk(clk), .rst(rst), .start(st[2]), .stop(sp[2]), .cont(ct[2]),
        .sel(sel_o[2]), .sel_en(en_o[2]), .busy(busy_o[2]), .done(done_o[2]), .wrap_tick(wrap_o[2]));
    decoder_scan_sequencer #(.DWELL_CYCLES(1), .LAST_INDEX(15)) u3 (.clk(clk), .rst(rst), .start(st[3]), .stop(sp[3]), .cont(ct[3]),
        .sel(sel_o[3]), .sel_en(en_o[3]), .busy(busy_o[3]), .done(done_o[3]), .wrap_tick(wrap_o[3]));
    decoder_scan_sequencer #(.DWELL_CYCLES(1), .LAST_INDEX(0)) u4 (.clk(clk), .rst(rst), .start(st[4]), .stop(sp[4]), .cont(ct[4]),
        .sel(sel_o[4]), .sel_en(en_o[4]), .busy(busy_o[4]), .done(done_o[4]), .wrap_tick(wrap_o[4]));
    decoder_scan_sequencer #(.DWELL_CYCLES(2), .LAST_INDEX(2)) u5 (.clk(clk), .rst(rst), .start(st[5]), .stop(sp[5]), .cont(ct[5]),
        .sel(sel_o[5]), .sel_en(en_o[5]), .busy(busy_o[5]), .done(done_o[5]), .wrap_tick(wrap_o[5]));

    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;
    bit wper_en = 1'b0;
    int cyc = 0;
    int last_wrap = -1;

    task automatic chk(input string name, input int k, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            if (bad <= 30)
                $display("FAIL %s[%0d] actual=%0d required=%0d", name, k, act, exp);
        end
    endtask

    // Reference: q counts cycles into the pass, offset so a (virtual) blank precedes index 0.
    bit m_act [NI];
    int m_q [NI];
    bit m_done [NI];
    bit m_wrap [NI];

    always @(posedge clk) begin
        int p;
        for (int k = 0; k < NI; k++) begin
            p = DWA[k] + BL;
            m_done[k] = 1'b0;
            m_wrap[k] = 1'b0;
            if (rst) m_act[k] = 1'b0;
            else if (!m_act[k]) begin
                if (st[k] && !sp[k]) begin m_act[k] = 1'b1; m_q[k] = BL; end
            end else if (sp[k]) m_act[k] = 1'b0;
            else if (m_q[k] == (LIA[k] + 1) * p - 1) begin
                if (ct[k]) begin m_q[k] = 0; m_wrap[k] = 1'b1; end
                else begin m_act[k] = 1'b0; m_done[k] = 1'b1; end
            end else m_q[k]++;
        end
    end

    always @(negedge clk) begin
        int p, es, een;
        logic [15:0] dout;
        if (chk_en) begin
            cyc++;
            for (int k = 0; k < NI; k++) begin
                p = DWA[k] + BL;
                es = m_act[k] ? m_q[k] / p : 0;
                een = (m_act[k] && (m_q[k] % p) >= BL) ? 1 : 0;
                chk("sel", k, int'(sel_o[k]), es);
                chk("sel_en", k, int'(en_o[k]), een);
                chk("busy", k, int'(busy_o[k]), m_act[k] ? 1 : 0);
                chk("done", k, int'(done_o[k]), m_done[k] ? 1 : 0);
                chk("wrap_tick", k, int'(wrap_o[k]), m_wrap[k] ? 1 : 0);
            end
            dout = en_o[0] ? (16'd1 << sel_o[0]) : 16'd0;
            es = m_act[0] ? m_q[0] / (DWA[0] + BL) : 0;
            een = (m_act[0] && (m_q[0] % (DWA[0] + BL)) >= BL) ? 1 : 0;
            chk("dout", 0, int'(dout), een != 0 ? (1 << es) : 0);
            if (wper_en && wrap_o[1]) begin
                if (last_wrap >= 0) chk("wrap_period", 1, cyc - last_wrap, WRAP_P);
                last_wrap = cyc;
            end
        end
    end

    typedef struct {
        logic start, stop, cont;
        logic [3:0] sel;
        logic en, busy, done, wrap;
    } vec_t;
    vec_t tbl [12];
    int ntbl = 0;

    task automatic addv(input int s, input int p, input int sl, input int e, input int b, input int d);
        tbl[ntbl] = '{start: s != 0, stop: p != 0, cont: 1'b0, sel: 4'(sl), en: e != 0, busy: b != 0, done: d != 0, wrap: 1'b0};
        ntbl++;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        int found, n, cnt;
        rst = 1'b1;
        for (int k = 0; k < NI; k++) begin st[k] = 0; sp[k] = 0; ct[k] = 0; end
`ifdef SCAN_BLANK_EN
        addv(1,0,0,1,1,0); addv(0,0,0,1,1,0); addv(0,0,1,0,1,0); addv(0,0,1,1,1,0);
        addv(0,0,1,1,1,0); addv(0,0,2,0,1,0); addv(0,0,2,1,1,0); addv(0,0,2,1,1,0);
        addv(0,0,0,0,0,1); addv(1,0,0,1,1,0); addv(0,1,0,0,0,0); addv(1,1,0,0,0,0);
`else
        addv(1,0,0,1,1,0); addv(0,0,0,1,1,0); addv(0,0,1,1,1,0); addv(0,0,1,1,1,0);
        addv(0,0,2,1,1,0); addv(0,0,2,1,1,0); addv(0,0,0,0,0,1); addv(1,0,0,1,1,0);
        addv(0,1,0,0,0,0); addv(1,1,0,0,0,0);
`endif
        tick(); tick();
        chk_en = 1'b1;
        rst = 1'b0;

        st[0] = 1; tick(); st[0] = 0;
        repeat (40) tick();
        st[0] = 1; tick(); st[0] = 0;
        repeat (9) tick();
        rst = 1'b1; tick(); tick(); rst = 1'b0;
        chk("post_rst_busy", 0, int'(busy_o[0]), 0);
        repeat (3) tick();
        chk("post_rst_idle", 0, int'(en_o[0]), 0);

        ct[1] = 1; st[1] = 1; wper_en = 1'b1; tick(); st[1] = 0;
        repeat (40) tick();
        ct[1] = 0;
        found = 0;
        for (int i = 0; i < 40 && found == 0; i++) begin tick(); if (done_o[1]) found = 1; end
        chk("cont_done_seen", 1, found, 1);
        wper_en = 1'b0;

        st[2] = 1; tick(); st[2] = 0;
        found = 0;
        for (int i = 0; i < 100 && found == 0; i++) begin if (sel_o[2] == 4'd5) found = 1; else tick(); end
        chk("reach_sel5", 2, found, 1);
        sp[2] = 1; tick(); sp[2] = 0;
        chk("stop_sel", 2, int'(sel_o[2]), 0);
        chk("stop_busy", 2, int'(busy_o[2]), 0);
        chk("stop_done", 2, int'(done_o[2]), 0);
        st[2] = 1; sp[2] = 1; tick(); tick();
        chk("start_stop_idle", 2, int'(busy_o[2]), 0);
        st[2] = 0; sp[2] = 0; tick();

        st[3] = 1; tick(); st[3] = 0;
        n = 1;
        while (n < 60 && !done_o[3]) begin tick(); n++; end
        chk("done_at", 3, n, DONE_AT);

        ct[4] = 1; st[4] = 1; tick(); st[4] = 0;
        cnt = 0;
        repeat (10) begin tick(); if (wrap_o[4]) cnt++; end
        chk("wraps_in_10", 4, cnt, WRAPS10);
        sp[4] = 1; tick(); sp[4] = 0; ct[4] = 0;

        for (int i = 0; i < ntbl; i++) begin
            st[5] = tbl[i].start; sp[5] = tbl[i].stop; ct[5] = tbl[i].cont;
            tick();
            chk("tbl_sel", i, int'(sel_o[5]), int'(tbl[i].sel));
            chk("tbl_en", i, int'(en_o[5]), int'(tbl[i].en));
            chk("tbl_busy", i, int'(busy_o[5]), int'(tbl[i].busy));
            chk("tbl_done", i, int'(done_o[5]), int'(tbl[i].done));
            chk("tbl_wrap", i, int'(wrap_o[5]), int'(tbl[i].wrap));
        end
        st[5] = 0; sp[5] = 0; tick();

        repeat (3000) begin
            rst = ($urandom_range(0, 499) == 0);
            for (int k = 0; k < NI; k++) begin
                st[k] = ($urandom_range(0, 9) < 2);
                sp[k] = ($urandom_range(0, 59) == 0);
                if ($urandom_range(0, 19) == 0) ct[k] = ~ct[k];
            end
            tick();
        end
        rst = 1'b0;
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
